// File: rtl/fibonacci_lanes_gen_if.sv
// ---------------------------------------------------------------------------
// fibonacci_lanes_gen_if
//
// Groups the control and output-stream signals of fibonacci_lanes_gen.
//
//   start      run request from the control side (sampled only when idle)
//   seed_a     term T1
//   seed_b     term T2
//   count      number of terms to emit
//   out_valid  beat available
//   out_ready  consumer accepts the beat
//   out_num    LANES terms, lane i at [i*WIDTH +: WIDTH], lane 0 earliest
//   out_mask   lanes carrying real terms
//   out_last   final beat of the run
//   busy       generator not idle
//   done       one-cycle end-of-run pulse
//   overflow   sticky: some emitted term wrapped
//
// Modports:
//   master  the generator side (drives the stream and status)
//   slave   the control/consumer side
// ---------------------------------------------------------------------------
interface fibonacci_lanes_gen_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 4,
    parameter int CNT_W = 16
);
    logic                   start;
    logic [WIDTH-1:0]       seed_a;
    logic [WIDTH-1:0]       seed_b;
    logic [CNT_W-1:0]       count;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_num;
    logic [LANES-1:0]       out_mask;
    logic                   out_last;
    logic                   busy;
    logic                   done;
    logic                   overflow;

    modport master (
        input  start, seed_a, seed_b, count, out_ready,
        output out_valid, out_num, out_mask, out_last, busy, done, overflow
    );

    modport slave (
        output start, seed_a, seed_b, count, out_ready,
        input  out_valid, out_num, out_mask, out_last, busy, done, overflow
    );
endinterface

// File: rtl/fibonacci_lanes_gen.sv
// ---------------------------------------------------------------------------
// fibonacci_lanes_gen
//
// Generalised Fibonacci/Lucas generator: T(k) = T(k-2) + T(k-1) mod 2**WIDTH,
// programmable seeds and term count, LANES terms per beat on a valid/ready
// stream with back-pressure.
//
// Ports:
//   clk   clock, all logic on posedge
//   rst   synchronous active-high reset; aborts a run without a done pulse
//   bus   fibonacci_lanes_gen_if.master (start/seeds/count in,
//         out_valid/out_num/out_mask/out_last/busy/done/overflow out,
//         out_ready in)
//
// Parameters:
//   WIDTH  term width
//   LANES  terms per beat (1..8)
//   CNT_W  width of the term count
// ---------------------------------------------------------------------------
module fibonacci_lanes_gen #(
    parameter int WIDTH = 16,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    fibonacci_lanes_gen_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;

    // Pair (a, b) seeding the beat that will be built on the next load,
    // with per-term wrap flags so a wrap computed as lookahead is still
    // reported when that term is finally emitted.
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic                   aw_q, aw_d;
    logic                   bw_q, bw_d;

    // Terms still owed, counted from the first lane of the beat on the bus.
    logic [CNT_W-1:0]       rem_q, rem_d;

    logic [LANES*WIDTH-1:0] out_num_q, out_num_d;
    logic [LANES-1:0]       out_mask_q, out_mask_d;
    logic                   out_last_q, out_last_d;
    logic                   overflow_q, overflow_d;

    // Beat construction inputs: seeds when starting, stored pair otherwise.
    logic [WIDTH-1:0]       src_a;
    logic [WIDTH-1:0]       src_b;
    logic                   src_aw;
    logic                   src_bw;
    logic [CNT_W-1:0]       src_rem;

    // Beat construction results.
    logic [WIDTH-1:0]       t_c [LANES+2];
    logic                   w_c [LANES+2];
    logic [LANES*WIDTH-1:0] beat_num_c;
    logic [LANES-1:0]       beat_mask_c;
    logic                   beat_last_c;
    logic                   wrap_hit_c;

    // -----------------------------------------------------------------------
    // Source selection
    // -----------------------------------------------------------------------
    always_comb begin
        src_a   = a_q;
        src_b   = b_q;
        src_aw  = aw_q;
        src_bw  = bw_q;
        src_rem = rem_q - CNT_W'(LANES);
        if (state_q == IDLE) begin
            src_a   = bus.seed_a;
            src_b   = bus.seed_b;
            src_aw  = 1'b0;
            src_bw  = 1'b0;
            src_rem = bus.count;
        end
    end

    // -----------------------------------------------------------------------
    // Adder chain: LANES beat terms plus the two-term lookahead pair.
    // -----------------------------------------------------------------------
    always_comb begin
        logic [WIDTH:0] sum;
        sum         = '0;
        t_c         = '{default: '0};
        w_c         = '{default: 1'b0};
        beat_num_c  = '0;
        beat_mask_c = '0;
        wrap_hit_c  = 1'b0;

        t_c[0] = src_a;
        w_c[0] = src_aw;
        t_c[1] = src_b;
        w_c[1] = src_bw;
        for (int unsigned i = 2; i < LANES + 2; i++) begin
            sum    = {1'b0, t_c[i-2]} + {1'b0, t_c[i-1]};
            t_c[i] = sum[WIDTH-1:0];
            w_c[i] = sum[WIDTH];
        end

        // Only lanes that carry real terms may raise overflow; the
        // lookahead pair's wraps travel with the pair instead.
        for (int unsigned i = 0; i < LANES; i++) begin
            beat_mask_c[i] = (src_rem > CNT_W'(i));
            if (beat_mask_c[i]) begin
                beat_num_c[i*WIDTH +: WIDTH] = t_c[i];
                wrap_hit_c = wrap_hit_c | w_c[i];
            end
        end

        beat_last_c = (src_rem <= CNT_W'(LANES));
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath update
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        aw_d       = aw_q;
        bw_d       = bw_q;
        rem_d      = rem_q;
        out_num_d  = out_num_q;
        out_mask_d = out_mask_q;
        out_last_d = out_last_q;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    overflow_d = 1'b0;
                    if (bus.count == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = RUN;
                        out_num_d  = beat_num_c;
                        out_mask_d = beat_mask_c;
                        out_last_d = beat_last_c;
                        a_d        = t_c[LANES];
                        b_d        = t_c[LANES+1];
                        aw_d       = w_c[LANES];
                        bw_d       = w_c[LANES+1];
                        rem_d      = src_rem;
                        overflow_d = wrap_hit_c;
                    end
                end
            end

            RUN: begin
                if (bus.out_ready) begin
                    if (out_last_q) begin
                        state_d    = DONE;
                        out_num_d  = '0;
                        out_mask_d = '0;
                        out_last_d = 1'b0;
                    end else begin
                        out_num_d  = beat_num_c;
                        out_mask_d = beat_mask_c;
                        out_last_d = beat_last_c;
                        a_d        = t_c[LANES];
                        b_d        = t_c[LANES+1];
                        aw_d       = w_c[LANES];
                        bw_d       = w_c[LANES+1];
                        rem_d      = src_rem;
                        overflow_d = overflow_q | wrap_hit_c;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            aw_q       <= 1'b0;
            bw_q       <= 1'b0;
            rem_q      <= '0;
            out_num_q  <= '0;
            out_mask_q <= '0;
            out_last_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            aw_q       <= aw_d;
            bw_q       <= bw_d;
            rem_q      <= rem_d;
            out_num_q  <= out_num_d;
            out_mask_q <= out_mask_d;
            out_last_q <= out_last_d;
            overflow_q <= overflow_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.out_valid = (state_q == RUN);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.out_num   = out_num_q;
    assign bus.out_mask  = out_mask_q;
    assign bus.out_last  = out_last_q;
    assign bus.overflow  = overflow_q;

endmodule
